// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: control-bundle layout,
// register-address width and the decode-stage opcodes.
package pipe_pkg;

    localparam int unsigned CTRL_W     = 9;
    localparam int unsigned REG_ADDR_W = 5;

    localparam int unsigned CTRL_ALUSRC   = 0;
    localparam int unsigned CTRL_ALUOP_LO = 1;
    localparam int unsigned CTRL_ALUOP_HI = 2;
    localparam int unsigned CTRL_REGDST   = 3;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_MEMREAD  = 5;
    localparam int unsigned CTRL_MEMWRITE = 6;
    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 8;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_BEQ   = 6'b000100,
        OP_J     = 6'b000010
    } opcode_e;

endpackage

// File: rtl/load_use_hazard.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle bubble unless that instruction is flushed.
module load_use_hazard
    import pipe_pkg::*;
(
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  stall
);

    always_comb begin
        hazard = 1'b0;
        // Address compare only qualified by a load, so unknown IDs never leak out.
        if (ex_memread) begin
            hazard = (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        end
        stall = hazard && !flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded instruction, inserts bubbles on
// flush or load-use hazard, and counts bubbles with a saturating counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CTRL_W-1:0]     ctrl_i,
    input  logic                  flush_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic [CTRL_W-1:0]     ctrl_o,
    output logic [DATA_W-1:0]     rs_data_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] rs_addr_o,
    output logic [REG_ADDR_W-1:0] rt_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    logic [CTRL_W-1:0]     ctrl_q,    ctrl_d;
    logic [DATA_W-1:0]     rs_data_q, rs_data_d;
    logic [DATA_W-1:0]     rt_data_q, rt_data_d;
    logic [DATA_W-1:0]     imm_q,     imm_d;
    logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  hazard;
    logic                  bubble;

    load_use_hazard u_hazard (
        .ex_memread (ctrl_q[CTRL_MEMREAD]),
        .ex_rt      (rt_addr_q),
        .id_rs      (rs_addr_i),
        .id_rt      (rt_addr_i),
        .flush      (flush_i),
        .hazard     (hazard),
        .stall      (stall_o)
    );

    always_comb begin
        bubble    = flush_i || hazard;
        ctrl_d    = ctrl_i;
        rs_data_d = rs_data_i;
        rt_data_d = rt_data_i;
        imm_d     = imm_i;
        rs_addr_d = rs_addr_i;
        rt_addr_d = rt_addr_i;
        rd_addr_d = rd_addr_i;
        cnt_d     = cnt_q;
        if (bubble) begin
            ctrl_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_addr_d = '0;
            rt_addr_d = '0;
            rd_addr_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ctrl_o       = ctrl_q;
    assign rs_data_o    = rs_data_q;
    assign rt_data_o    = rt_data_q;
    assign imm_o        = imm_q;
    assign rs_addr_o    = rs_addr_q;
    assign rt_addr_o    = rt_addr_q;
    assign rd_addr_o    = rd_addr_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a transaction-level model of the pipeline register.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [8:0]  ctrl_i;
    logic        flush_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;

    logic [8:0]  ctrl_o;
    logic [31:0] rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic        stall_o;
    logic [15:0] bubble_cnt_o;

    logic [8:0]  s_ctrl_o;
    logic [31:0] s_rs_data_o, s_rt_data_o, s_imm_o;
    logic [4:0]  s_rs_addr_o, s_rt_addr_o, s_rd_addr_o;
    logic        s_stall_o;
    logic [3:0]  s_bubble_cnt_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model: the instruction currently held in EX, plus an unbounded bubble count.
    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs_addr, rt_addr, rd_addr;
    } instr_t;

    instr_t      m_ex;
    int unsigned m_bubbles;

    localparam logic [8:0] CTRL_RTYPE = 9'b010001110;
    localparam logic [8:0] CTRL_LW    = 9'b110100001;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .flush_i(flush_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .ctrl_o(ctrl_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .flush_i(flush_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .ctrl_o(s_ctrl_o), .rs_data_o(s_rs_data_o), .rt_data_o(s_rt_data_o), .imm_o(s_imm_o),
        .rs_addr_o(s_rs_addr_o), .rt_addr_o(s_rt_addr_o), .rd_addr_o(s_rd_addr_o),
        .stall_o(s_stall_o), .bubble_cnt_o(s_bubble_cnt_o)
    );

    function automatic logic model_hazard();
        return m_ex.ctrl[5] && (m_ex.rt_addr != 5'd0) &&
               ((m_ex.rt_addr == rs_addr_i) || (m_ex.rt_addr == rt_addr_i));
    endfunction

    function automatic logic model_stall();
        return model_hazard() && !flush_i;
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
    endfunction

    function automatic logic [3:0] exp_cnt4();
        return (m_bubbles > 15) ? 4'hF : 4'(m_bubbles);
    endfunction

    function automatic logic [119:0] exp_vec();
        return {m_ex.ctrl, m_ex.rs_addr, m_ex.rt_addr, m_ex.rd_addr,
                m_ex.rs_data, m_ex.rt_data, m_ex.imm};
    endfunction

    function automatic logic [119:0] dut_vec();
        return {ctrl_o, rs_addr_o, rt_addr_o, rd_addr_o, rs_data_o, rt_data_o, imm_o};
    endfunction

    // Advance one clock: update the model from the inputs in force, then sample after the edge.
    task automatic tick();
        instr_t nxt;
        nxt = '{ctrl: ctrl_i, rs_data: rs_data_i, rt_data: rt_data_i, imm: imm_i,
                rs_addr: rs_addr_i, rt_addr: rt_addr_i, rd_addr: rd_addr_i};
        if (!rst_i) begin
            m_ex      = '{default: '0};
            m_bubbles = 0;
        end else if (flush_i || model_hazard()) begin
            m_ex      = '{default: '0};
            m_bubbles = m_bubbles + 1;
        end else begin
            m_ex = nxt;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [8:0] c, input logic fl, input logic [4:0] rsa,
                         input logic [4:0] rta, input logic [4:0] rda,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im);
        ctrl_i = c; flush_i = fl; rs_addr_i = rsa; rt_addr_i = rta; rd_addr_i = rda;
        rs_data_i = rsd; rt_data_i = rtd; imm_i = im;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        drive(9'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive(9'h1FF, 1'b1, 5'd7, 5'd7, 5'd7, 32'hDEADBEEF, 32'h12345678, 32'hFFFF0000);
        tick();
        tick();
        total++;
        if (dut_vec() !== 120'h0) begin
            bad++; $display("FAIL reset_regs got=%h want=0", dut_vec());
        end
        total++;
        if (bubble_cnt_o !== 16'd0 || s_bubble_cnt_o !== 4'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", bubble_cnt_o, s_bubble_cnt_o);
        end
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL reset_stall got=%b want=0", stall_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_passthrough();
        do_reset();
        drive(CTRL_RTYPE, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0000_0020);
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL pass_stall got=%b want=0", stall_o);
        end
        tick();
        total++;
        if (ctrl_o !== CTRL_RTYPE || rs_data_o !== 32'd5 || rt_data_o !== 32'd7 ||
            rd_addr_o !== 5'd3 || rs_addr_o !== 5'd1 || rt_addr_o !== 5'd2 ||
            imm_o !== 32'h0000_0020) begin
            bad++; $display("FAIL pass_regs got=%h want ctrl=%h rs=5 rt=7 rd=3", dut_vec(), CTRL_RTYPE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(CTRL_LW, 1'b0, 5'd4, 5'd8, 5'd0, 32'd100, 32'd0, 32'd16);
        tick();
        drive(CTRL_RTYPE, 1'b0, 5'd8, 5'd2, 5'd10, 32'd11, 32'd22, 32'd0);
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL lu_stall got=%b want=1", stall_o);
        end
        tick();
        total++;
        if (ctrl_o !== 9'h0 || bubble_cnt_o !== 16'd1 || rd_addr_o !== 5'd0) begin
            bad++; $display("FAIL lu_bubble got ctrl=%h cnt=%0d rd=%0d want 0/1/0", ctrl_o, bubble_cnt_o, rd_addr_o);
        end
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL lu_release got=%b want=0", stall_o);
        end
        tick();
        total++;
        if (ctrl_o !== CTRL_RTYPE || rs_addr_o !== 5'd8 || rd_addr_o !== 5'd10 || bubble_cnt_o !== 16'd1) begin
            bad++; $display("FAIL lu_held got ctrl=%h rs=%0d rd=%0d cnt=%0d want %h/8/10/1",
                            ctrl_o, rs_addr_o, rd_addr_o, bubble_cnt_o, CTRL_RTYPE);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(CTRL_LW, 1'b0, 5'd4, 5'd0, 5'd0, 32'd1, 32'd2, 32'd3);
        tick();
        drive(CTRL_RTYPE, 1'b0, 5'd0, 5'd0, 5'd6, 32'd9, 32'd9, 32'd0);
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL zero_stall got=%b want=0", stall_o);
        end
        tick();
        total++;
        if (ctrl_o !== CTRL_RTYPE || rd_addr_o !== 5'd6 || bubble_cnt_o !== 16'd0) begin
            bad++; $display("FAIL zero_nobubble got ctrl=%h rd=%0d cnt=%0d want %h/6/0",
                            ctrl_o, rd_addr_o, bubble_cnt_o, CTRL_RTYPE);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        drive(CTRL_LW, 1'b0, 5'd4, 5'd9, 5'd0, 32'd1, 32'd2, 32'd3);
        tick();
        drive(CTRL_RTYPE, 1'b1, 5'd3, 5'd9, 5'd12, 32'd7, 32'd8, 32'd0);
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL fh_stall got=%b want=0", stall_o);
        end
        tick();
        total++;
        if (ctrl_o !== 9'h0 || rs_data_o !== 32'd0 || bubble_cnt_o !== 16'd1) begin
            bad++; $display("FAIL fh_bubble got ctrl=%h rs=%0d cnt=%0d want 0/0/1", ctrl_o, rs_data_o, bubble_cnt_o);
        end
        drive(CTRL_RTYPE, 1'b0, 5'd3, 5'd9, 5'd12, 32'd7, 32'd8, 32'd0);
        tick();
        total++;
        if (ctrl_o !== CTRL_RTYPE || bubble_cnt_o !== 16'd1) begin
            bad++; $display("FAIL fh_single got ctrl=%h cnt=%0d want %h/1", ctrl_o, bubble_cnt_o, CTRL_RTYPE);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(9'(i), 1'b1, 5'(i), 5'(i), 5'(i), 32'(i), 32'(i), 32'(i));
            tick();
        end
        total++;
        if (s_bubble_cnt_o !== 4'd15) begin
            bad++; $display("FAIL sat_hold got=%0d want=15", s_bubble_cnt_o);
        end
        total++;
        if (bubble_cnt_o !== 16'd20) begin
            bad++; $display("FAIL sat_wide got=%0d want=20", bubble_cnt_o);
        end
        rst_i = 1'b0;
        drive(CTRL_LW, 1'b1, 5'd1, 5'd1, 5'd1, 32'd1, 32'd1, 32'd1);
        tick();
        rst_i = 1'b1;
        total++;
        if (s_bubble_cnt_o !== 4'd0 || bubble_cnt_o !== 16'd0) begin
            bad++; $display("FAIL sat_reset got=%0d/%0d want=0/0", s_bubble_cnt_o, bubble_cnt_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [8:0] c;
            c = 9'($urandom);
            c[5] = ($urandom_range(0, 99) < 40);
            rst_i = ($urandom_range(0, 99) >= 3);
            drive(c, ($urandom_range(0, 99) < 12),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                  $urandom, $urandom, $urandom);
            total++;
            if (stall_o !== model_stall() || s_stall_o !== model_stall()) begin
                bad++; $display("FAIL rnd_stall[%0d] got=%b/%b want=%b", i, stall_o, s_stall_o, model_stall());
            end
            tick();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL rnd_regs[%0d] got=%h want=%h", i, dut_vec(), exp_vec());
            end
            total++;
            if (bubble_cnt_o !== exp_cnt16() || s_bubble_cnt_o !== exp_cnt4()) begin
                bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d want=%0d/%0d",
                                i, bubble_cnt_o, s_bubble_cnt_o, exp_cnt16(), exp_cnt4());
            end
        end
        rst_i = 1'b1;
    endtask

    initial begin
        m_ex      = '{default: '0};
        m_bubbles = 0;
        rst_i     = 1'b0;
        drive(9'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(posedge clk_i);
        #1;
        test_reset();
        test_passthrough();
        test_load_use();
        test_zero_reg();
        test_flush_hazard();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the five-stage MIPS core. It sits directly downstream of the instruction-decode control unit and the register file.
- Each cycle it latches the 9-bit control bundle, the operand data, the sign-extended immediate and the register addresses.
- It owns load-use hazard detection: on a hazard it inserts a bubble and holds PC and IF/ID.
- It also squashes the decoded instruction on a branch or jump flush, and counts inserted bubbles for performance debug.

Parameters:
- DATA_W, 32, operand and immediate width
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- ctrl_i  in  9  control bundle from decode: [0] ALUSrc, [2:1] ALUOp, [3] RegDst, [4] Branch, [5] MemRead, [6] MemWrite, [7] RegWrite, [8] MemtoReg
- flush_i  in  1  squash the decode-stage instruction (branch taken or jump)
- rs_data_i  in  DATA_W  register-file read data, rs
- rt_data_i  in  DATA_W  register-file read data, rt
- imm_i  in  DATA_W  sign-extended immediate; bits [5:0] carry funct
- rs_addr_i, rt_addr_i, rd_addr_i  in  5 each  decode-stage register addresses
- ctrl_o  out  9  registered control bundle, same bit layout as ctrl_i
- rs_data_o, rt_data_o, imm_o  out  DATA_W each  registered operands
- rs_addr_o, rt_addr_o, rd_addr_o  out  5 each  registered addresses
- stall_o  out  1  combinational; 1 = PC and IF/ID hold this cycle
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clk_i.
  - rst_i=0 at an edge clears every registered output and bubble_cnt_o to 0, whatever the other inputs are.
- Hazard (combinational, from the current ID/EX contents and the ID addresses):
  - hazard = ctrl_o[5] & (rt_addr_o != 0) & ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i)).
  - stall_o = hazard & ~flush_i.
- Per-edge action when rst_i=1, in priority order:
  1. flush_i=1 -> load bubble.
  2. hazard=1 -> load bubble.
  3. Otherwise -> normal load: every *_o takes its *_i value; ctrl_o = ctrl_i.
- Bubble load: every registered output (control, data, immediate, addresses) becomes 0. MemRead is therefore 0, so a stall lasts exactly one cycle and cannot self-retrigger.
- Latency: one cycle from input to output. No back-pressure exists other than stall_o.
- Counter:
  - Increments by 1 on each bubble load, whether from flush or hazard.
  - Saturates at 2^CNT_W-1 and holds there.
  - Cleared only by reset.
- Simultaneous flush and hazard: exactly one bubble, counter +1, stall_o=0 (the squashed instruction is not held).
- Register $0: a load targeting $0 never stalls.
- Reset mid-stall: the next edge gives all zeros. stall_o falls combinationally once ctrl_o[5]=0.
- No internal X: if the current ID/EX instruction is not a load, stall_o is driven 0 regardless of address inputs.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W=9.
  - Bit-index constants CTRL_ALUSRC=0, CTRL_ALUOP_LO=1, CTRL_ALUOP_HI=2, CTRL_REGDST=3, CTRL_BRANCH=4, CTRL_MEMREAD=5, CTRL_MEMWRITE=6, CTRL_REGWRITE=7, CTRL_MEMTOREG=8.
  - REG_ADDR_W=5.
  - The decode-stage opcode constants (R-type 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010).
- One combinational sub-module, load_use_hazard: inputs ex_memread, ex_rt, id_rs, id_rt, flush; outputs hazard and stall. id_ex_stage holds all registers and the counter.

Test Plan:
- Reset: hold rst_i=0 for 2 edges with ctrl_i=9'h1FF and rs_data_i=32'hDEADBEEF -> all outputs 0, bubble_cnt_o=0, stall_o=0.
- Normal R-type pass-through: ctrl_i=9'b010001110, rs_data_i=5, rt_data_i=7, rd_addr_i=3 -> after one edge ctrl_o=9'b010001110, rs_data_o=5, rt_data_o=7, rd_addr_o=3; stall_o=0.
- Load-use:
  - Stimulus: lw with ctrl_i=9'b110100001 and rt_addr_i=8 latched; next ID presents rs_addr_i=8.
  - Required: stall_o=1 that cycle; next edge ctrl_o=0 and bubble_cnt_o=1; then stall_o=0 and the held instruction loads on the following edge.
- $0 load: lw with rt_addr_i=0 followed by rs_addr_i=0 -> stall_o=0, no bubble, counter unchanged.
- Flush with hazard: lw to $9 in EX, ID rt_addr_i=9, flush_i=1 -> stall_o=0, one bubble, bubble_cnt_o +1.
- Saturation with CNT_W=4: 20 consecutive flush cycles -> bubble_cnt_o stops at 15; then one reset edge -> 0.
